// File: rtl/func_sweep_pkg.sv
// Shared types and sizes for the func sweep sequencer.
// Optional compare feature is enabled with FUNC_SWEEP_CHECK_EN.
package func_sweep_pkg;

  localparam int N_VEC = 16;
  localparam int RES_W = 32;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/func_sweep_ctrl_if.sv
// Handshake, vector-drive and capture bus between a host and the sweep controller.
// master = host side (drives start/abort and returns func outputs),
// slave  = func_sweep_ctrl.
// FUNC_SWEEP_CHECK_EN adds the expected word and the compare results.
interface func_sweep_ctrl_if;
  import func_sweep_pkg::*;

  logic             start;
  logic             abort;
  logic             y_in;
  logic             z_in;
  logic             vec_a;
  logic             vec_b;
  logic             vec_c;
  logic             vec_d;
  logic [IDX_W-1:0] vec_idx;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;
`ifdef FUNC_SWEEP_CHECK_EN
  logic [RES_W-1:0] expected;
  logic [4:0]       mismatch_cnt;
  logic             pass;

  modport master (
    output start, abort, y_in, z_in, expected,
    input  vec_a, vec_b, vec_c, vec_d, vec_idx, busy, done, result,
           mismatch_cnt, pass
  );

  modport slave (
    input  start, abort, y_in, z_in, expected,
    output vec_a, vec_b, vec_c, vec_d, vec_idx, busy, done, result,
           mismatch_cnt, pass
  );
`else
  modport master (
    output start, abort, y_in, z_in,
    input  vec_a, vec_b, vec_c, vec_d, vec_idx, busy, done, result
  );

  modport slave (
    input  start, abort, y_in, z_in,
    output vec_a, vec_b, vec_c, vec_d, vec_idx, busy, done, result
  );
`endif

endinterface

// File: rtl/func_sweep_cmp.sv
// Per-vector compare of captured func outputs against an expected word,
// counting mismatching vectors and producing a pass flag at the end of a sweep.
// Only instantiated when FUNC_SWEEP_CHECK_EN is defined.
module func_sweep_cmp
  import func_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             sample_i,
  input  logic             finish_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [1:0]       obs_i,
  input  logic [RES_W-1:0] expected_i,
  output logic [4:0]       mismatch_cnt_o,
  output logic             pass_o
);

  logic [4:0] mismatchCnt_q;
  logic [4:0] mismatchCnt_d;
  logic       pass_q;
  logic       vecMiss;

  // A vector misses when its captured {z,y} pair differs from its expected pair
  always_comb begin
    vecMiss       = sample_i && (obs_i != expected_i[2*idx_i +: 2]);
    mismatchCnt_d = mismatchCnt_q + (vecMiss ? 5'd1 : 5'd0);
  end

  // Counter and pass flag clear on an accepted start; pass is judged once the sweep completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatchCnt_q <= '0;
      pass_q        <= 1'b0;
    end else if (clear_i) begin
      mismatchCnt_q <= '0;
      pass_q        <= 1'b0;
    end else begin
      mismatchCnt_q <= mismatchCnt_d;
      if (finish_i) begin
        pass_q <= (mismatchCnt_q == 5'd0);
      end
    end
  end

  assign mismatch_cnt_o = mismatchCnt_q;
  assign pass_o         = pass_q;

endmodule

// File: rtl/func_sweep_ctrl.sv
// Exhaustive sweep sequencer for the 4-in/2-out func block: drives all 16
// vectors, waits SETTLE_CYCLES, samples y/z into a 32-bit result word.
// Define FUNC_SWEEP_CHECK_EN to add the expected-value compare unit.
module func_sweep_ctrl
  import func_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  func_sweep_ctrl_if.slave sweep_if
);

  localparam logic [IDX_W-1:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? IDX_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);
  localparam state_e VEC_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] settleCnt_q;
  logic             busy_q;
  logic             done_q;
  logic [RES_W-1:0] result_q;
  logic             acceptStart;
  logic             abortHit;

  // The done-pulse cycle still belongs to the finished sweep, so start is not taken there
  always_comb begin
    acceptStart = (state_q == IDLE) && sweep_if.start && !sweep_if.abort && !done_q;
    abortHit    = (state_q != IDLE) && sweep_if.abort;
  end

  // Sweep FSM with registered vector, busy, done and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      settleCnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (abortHit) begin
        state_q     <= IDLE;
        idx_q       <= '0;
        settleCnt_q <= '0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (acceptStart) begin
              idx_q       <= '0;
              settleCnt_q <= '0;
              result_q    <= '0;
              busy_q      <= 1'b1;
              state_q     <= VEC_ENTRY;
            end
          end
          SETTLE: begin
            if (settleCnt_q == SETTLE_LAST) begin
              settleCnt_q <= '0;
              state_q     <= SAMPLE;
            end else begin
              settleCnt_q <= settleCnt_q + 1'b1;
            end
          end
          SAMPLE: begin
            result_q[2*idx_q +: 2] <= {sweep_if.z_in, sweep_if.y_in};
            if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= VEC_ENTRY;
            end
          end
          DONE: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sweep_if.vec_a   = idx_q[3];
  assign sweep_if.vec_b   = idx_q[2];
  assign sweep_if.vec_c   = idx_q[1];
  assign sweep_if.vec_d   = idx_q[0];
  assign sweep_if.vec_idx = idx_q;
  assign sweep_if.busy    = busy_q;
  assign sweep_if.done    = done_q;
  assign sweep_if.result  = result_q;

`ifdef FUNC_SWEEP_CHECK_EN
  func_sweep_cmp u_cmp (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (acceptStart),
    .sample_i       ((state_q == SAMPLE) && !abortHit),
    .finish_i       ((state_q == DONE) && !abortHit),
    .idx_i          (idx_q),
    .obs_i          ({sweep_if.z_in, sweep_if.y_in}),
    .expected_i     (sweep_if.expected),
    .mismatch_cnt_o (sweep_if.mismatch_cnt),
    .pass_o         (sweep_if.pass)
  );
`endif

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Self-checking bench for func_sweep_ctrl with a behavioural func stand-in
// (y = a^b^c^d, z = (a&b)|(c&d)). One DUT uses SETTLE_CYCLES=1, one uses 0.
// Compare-unit checks are included when FUNC_SWEEP_CHECK_EN is defined.
module tb_func_sweep_ctrl;
  import func_sweep_pkg::*;

  localparam logic [15:0] Y_MASK = 16'h6996;
  localparam logic [15:0] Z_MASK = 16'hF888;

  logic clk = 1'b0;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] golden;
  logic [31:0] expQ[$];

  func_sweep_ctrl_if bus1 ();
  func_sweep_ctrl_if bus0 ();

  func_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .sweep_if (bus1.slave)
  );

  func_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .sweep_if (bus0.slave)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Behavioural func block fed back from each DUT's vector outputs
  assign bus1.y_in = bus1.vec_a ^ bus1.vec_b ^ bus1.vec_c ^ bus1.vec_d;
  assign bus1.z_in = (bus1.vec_a & bus1.vec_b) | (bus1.vec_c & bus1.vec_d);
  assign bus0.y_in = bus0.vec_a ^ bus0.vec_b ^ bus0.vec_c ^ bus0.vec_d;
  assign bus0.z_in = (bus0.vec_a & bus0.vec_b) | (bus0.vec_c & bus0.vec_d);

  function automatic logic [31:0] interleave(input logic [15:0] ym, input logic [15:0] zm);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[2*i]   = ym[i];
      r[2*i+1] = zm[i];
    end
    return r;
  endfunction

  function automatic logic [15:0] pickBits(input logic [31:0] r, input int ofs);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i] = r[2*i+ofs];
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit sel, input logic st, input logic ab);
    if (sel) begin
      bus1.start = st;
      bus1.abort = ab;
    end else begin
      bus0.start = st;
      bus0.abort = ab;
    end
  endtask

  // Full sweep on the SETTLE_CYCLES=1 DUT with scoreboard result check
  task automatic runSweep1(input logic [31:0] expRes, input string tag);
    int doneAt;
    logic [31:0] e;
    expQ.push_back(expRes);
    applyStimulus(1, 1'b1, 1'b0);
    tick;
    applyStimulus(1, 1'b0, 1'b0);
    doneAt = 0;
    for (int k = 1; k <= 40 && doneAt == 0; k++) begin
      tick;
      if (bus1.done) doneAt = k;
    end
    checkOutput({tag, "_latency"}, doneAt, 33);
    e = expQ.pop_front();
    checkOutput({tag, "_result"}, bus1.result, e);
  endtask

  initial begin
    int doneAt;
    int nDone;
    logic st;
    logic [31:0] e;
    logic [31:0] bad;

    golden = interleave(Y_MASK, Z_MASK);
    rst_n  = 1'b0;
    applyStimulus(1, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 1'b0);
`ifdef FUNC_SWEEP_CHECK_EN
    bus1.expected = golden;
    bus0.expected = golden;
`endif
    $display("[TB] reset with start held high");
    for (int k = 0; k < 4; k++) begin
      tick;
      checkOutput("rst_busy1", bus1.busy, 0);
      checkOutput("rst_busy0", bus0.busy, 0);
    end
    checkOutput("rst_done", bus1.done, 0);
    checkOutput("rst_result", bus1.result, 0);
    checkOutput("rst_idx", bus1.vec_idx, 0);
    checkOutput("rst_vec", {bus1.vec_a, bus1.vec_b, bus1.vec_c, bus1.vec_d}, 0);
`ifdef FUNC_SWEEP_CHECK_EN
    checkOutput("rst_mcnt", bus1.mismatch_cnt, 0);
    checkOutput("rst_pass", bus1.pass, 0);
`endif
    applyStimulus(1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick;
    checkOutput("post_rst_busy1", bus1.busy, 0);
    checkOutput("post_rst_busy0", bus0.busy, 0);

    $display("[TB] full sweep, SETTLE_CYCLES=1");
    expQ.push_back(golden);
    applyStimulus(1, 1'b1, 1'b0);
    tick;
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("s1_busy_start", bus1.busy, 1);
    checkOutput("s1_idx_start", bus1.vec_idx, 0);
    doneAt = 0;
    for (int k = 1; k <= 40 && doneAt == 0; k++) begin
      tick;
      if (k == 5) checkOutput("s1_idx_k5", bus1.vec_idx, 2);
      if (bus1.done) doneAt = k;
    end
    checkOutput("s1_latency", doneAt, 33);
    e = expQ.pop_front();
    checkOutput("s1_result", bus1.result, e);
    checkOutput("s1_ymask", pickBits(bus1.result, 0), Y_MASK);
    checkOutput("s1_zmask", pickBits(bus1.result, 1), Z_MASK);
    checkOutput("s1_busy_at_done", bus1.busy, 0);
`ifdef FUNC_SWEEP_CHECK_EN
    checkOutput("s1_mcnt", bus1.mismatch_cnt, 0);
    checkOutput("s1_pass", bus1.pass, 1);
`endif
    tick;
    checkOutput("s1_done_one_cycle", bus1.done, 0);
    repeat (3) tick;
    checkOutput("s1_result_hold", bus1.result, golden);

    $display("[TB] full sweep, SETTLE_CYCLES=0");
    expQ.push_back(golden);
    applyStimulus(0, 1'b1, 1'b0);
    tick;
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("s0_idx_0", bus0.vec_idx, 0);
    doneAt = 0;
    for (int k = 1; k <= 25; k++) begin
      tick;
      if (k <= 15) checkOutput("s0_idx_step", bus0.vec_idx, k);
      if (k == 9) checkOutput("s0_vecbits", {bus0.vec_a, bus0.vec_b, bus0.vec_c, bus0.vec_d}, 9);
      if (bus0.done && doneAt == 0) doneAt = k;
    end
    checkOutput("s0_latency", doneAt, 17);
    e = expQ.pop_front();
    checkOutput("s0_result", bus0.result, e);

    $display("[TB] start held and re-pulsed while busy");
    expQ.push_back(golden);
    applyStimulus(1, 1'b1, 1'b0);
    tick;
    doneAt = 0;
    nDone  = 0;
    for (int k = 1; k <= 45; k++) begin
      st = (k <= 7) || (k == 10) || (k >= 32 && k <= 34);
      applyStimulus(1, st, 1'b0);
      tick;
      if (bus1.done) begin
        nDone++;
        if (doneAt == 0) doneAt = k;
      end
    end
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("rs_latency", doneAt, 33);
    checkOutput("rs_done_count", nDone, 1);
    checkOutput("rs_busy_after", bus1.busy, 0);
    e = expQ.pop_front();
    checkOutput("rs_result", bus1.result, e);

    $display("[TB] abort mid-sweep");
    expQ.push_back(golden & 32'h0000_00FF);
    applyStimulus(1, 1'b1, 1'b0);
    tick;
    applyStimulus(1, 1'b0, 1'b0);
    repeat (8) tick;
    applyStimulus(1, 1'b0, 1'b1);
    tick;
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("ab_busy", bus1.busy, 0);
    checkOutput("ab_idx", bus1.vec_idx, 0);
    checkOutput("ab_vec", {bus1.vec_a, bus1.vec_b, bus1.vec_c, bus1.vec_d}, 0);
    nDone = 0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (bus1.done) nDone++;
    end
    checkOutput("ab_no_done", nDone, 0);
    e = expQ.pop_front();
    checkOutput("ab_partial", bus1.result, e);

    applyStimulus(1, 1'b1, 1'b1);
    tick;
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("ab_start_both", bus1.busy, 0);
    tick;
    checkOutput("ab_start_both_hold", bus1.result, golden & 32'h0000_00FF);
    runSweep1(golden, "ab_restart");

    $display("[TB] reset mid-sweep");
    applyStimulus(1, 1'b1, 1'b0);
    tick;
    applyStimulus(1, 1'b0, 1'b0);
    repeat (6) tick;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_busy", bus1.busy, 0);
    checkOutput("mr_result", bus1.result, 0);
    checkOutput("mr_idx", bus1.vec_idx, 0);
    tick;
    rst_n = 1'b1;
    tick;

`ifdef FUNC_SWEEP_CHECK_EN
    $display("[TB] compare unit");
    bad = golden ^ (32'h1 << 4) ^ (32'h1 << 14) ^ (32'h1 << 26);
    bus1.expected = bad;
    runSweep1(golden, "ck_bad");
    checkOutput("ck_bad_mcnt", bus1.mismatch_cnt, 3);
    checkOutput("ck_bad_pass", bus1.pass, 0);
    tick;
    bus1.expected = golden;
    runSweep1(golden, "ck_good");
    checkOutput("ck_good_mcnt", bus1.mismatch_cnt, 0);
    checkOutput("ck_good_pass", bus1.pass, 1);
`else
    bad = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
